// File: rtl/alu_decode_stage.sv
// MIPS-I decode/issue stage: turns an instruction word plus its register reads
// into the alu operation/operand set, held in an ID/EX register with stall and flush.
module alu_decode_stage #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] insn,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [5:0]  operation,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [5:0]  shift_amount,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal
);

  typedef enum logic [5:0] {
    OP_ADD = 6'd0,
    OP_SUB = 6'd1,
    OP_MUL = 6'd2,
    OP_DIV = 6'd3,
    OP_SLL = 6'd4,
    OP_SRL = 6'd5,
    OP_SLT = 6'd6,
    OP_AND = 6'd7,
    OP_OR  = 6'd8,
    OP_XOR = 6'd9,
    OP_NOR = 6'd10,
    OP_SRA = 6'd11,
    OP_LUI = 6'd12
  } alu_op_e;

  // Primary opcodes (insn[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (insn[5:0])
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef struct packed {
    logic        valid;
    alu_op_e     operation;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  shift_amount;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } idex_t;

  typedef enum logic [1:0] {
    MODE_BUBBLE,
    MODE_LOAD,
    MODE_HOLD
  } mode_e;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_field;
  logic [4:0]  rd_field;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign opcode   = insn[31:26];
  assign rt_field = insn[20:16];
  assign rd_field = insn[15:11];
  assign shamt    = insn[10:6];
  assign funct    = insn[5:0];
  assign imm      = insn[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  idex_t dec;
  idex_t pipe;
  mode_e mode;
  logic  legal;
  logic  is_store;

  always_comb begin
    // NOTE: every field gets a default before the case tree, so no path can
    // leave a signal unassigned and infer a latch.
    dec          = '0;
    dec.valid    = 1'b1;
    dec.op1      = rs_data;
    dec.op2      = rt_data;
    legal        = 1'b1;
    is_store     = 1'b0;

    if (insn != NOP_WORD) begin
      case (opcode)
        OPC_RTYPE: begin
          dec.dest_reg = rd_field;
          case (funct)
            FN_ADD, FN_ADDU:   dec.operation = OP_ADD;
            FN_SUB, FN_SUBU:   dec.operation = OP_SUB;
            FN_MULT, FN_MULTU: dec.operation = OP_MUL;
            FN_DIV, FN_DIVU:   dec.operation = OP_DIV;
            FN_SLT:            dec.operation = OP_SLT;
            FN_AND:            dec.operation = OP_AND;
            FN_OR:             dec.operation = OP_OR;
            FN_XOR:            dec.operation = OP_XOR;
            FN_NOR:            dec.operation = OP_NOR;
            FN_SLL: begin
              dec.operation    = OP_SLL;
              dec.shift_amount = {1'b0, shamt};
            end
            FN_SRL: begin
              dec.operation    = OP_SRL;
              dec.shift_amount = {1'b0, shamt};
            end
            FN_SRA: begin
              dec.operation    = OP_SRA;
              dec.shift_amount = {1'b0, shamt};
            end
            // Variable shifts take their count from the rs register value.
            FN_SLLV: begin
              dec.operation    = OP_SLL;
              dec.shift_amount = {1'b0, rs_data[4:0]};
            end
            FN_SRLV: begin
              dec.operation    = OP_SRL;
              dec.shift_amount = {1'b0, rs_data[4:0]};
            end
            FN_SRAV: begin
              dec.operation    = OP_SRA;
              dec.shift_amount = {1'b0, rs_data[4:0]};
            end
            default: legal = 1'b0;
          endcase
        end
        OPC_ADDI, OPC_ADDIU: begin
          dec.operation = OP_ADD;
          dec.op2       = imm_sext;
          dec.dest_reg  = rt_field;
        end
        OPC_SLTI: begin
          dec.operation = OP_SLT;
          dec.op2       = imm_sext;
          dec.dest_reg  = rt_field;
        end
        OPC_ANDI: begin
          dec.operation = OP_AND;
          dec.op2       = imm_zext;
          dec.dest_reg  = rt_field;
        end
        OPC_ORI: begin
          dec.operation = OP_OR;
          dec.op2       = imm_zext;
          dec.dest_reg  = rt_field;
        end
        OPC_XORI: begin
          dec.operation = OP_XOR;
          dec.op2       = imm_zext;
          dec.dest_reg  = rt_field;
        end
        OPC_LUI: begin
          dec.operation = OP_LUI;
          dec.op2       = imm_zext;
          dec.dest_reg  = rt_field;
        end
        OPC_LW: begin
          dec.operation = OP_ADD;
          dec.op2       = imm_sext;
          dec.dest_reg  = rt_field;
          dec.mem_read  = 1'b1;
        end
        OPC_SW: begin
          dec.operation = OP_ADD;
          dec.op2       = imm_sext;
          dec.dest_reg  = rt_field;
          dec.mem_write = 1'b1;
          is_store      = 1'b1;
        end
        default: legal = 1'b0;
      endcase

      if (legal) begin
        dec.reg_write = ~is_store & (dec.dest_reg != 5'd0);
      end else begin
        // Unknown encodings still carry operands so a trap handler can inspect them.
        dec.illegal      = 1'b1;
        dec.operation    = OP_ADD;
        dec.op2          = rt_data;
        dec.shift_amount = '0;
        dec.dest_reg     = '0;
        dec.mem_read     = 1'b0;
        dec.mem_write    = 1'b0;
      end
    end
  end

  // Flush outranks stall; an idle cycle without flush or stall leaves a bubble.
  always_comb begin
    if (flush) begin
      mode = MODE_BUBBLE;
    end else if (stall) begin
      mode = MODE_HOLD;
    end else if (in_valid) begin
      mode = MODE_LOAD;
    end else begin
      mode = MODE_BUBBLE;
    end
  end

  // NOTE: the whole ID/EX register is reset, not just the valid bit, because
  // downstream control (reg_write, mem_write) must be quiet straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      case (mode)
        MODE_LOAD:   pipe <= dec;
        MODE_HOLD:   pipe <= pipe;
        default:     pipe <= '0;
      endcase
    end
  end

  assign in_ready     = ~stall;
  assign out_valid    = pipe.valid;
  assign operation    = pipe.operation;
  assign op1          = pipe.op1;
  assign op2          = pipe.op2;
  assign shift_amount = pipe.shift_amount;
  assign dest_reg     = pipe.dest_reg;
  assign reg_write    = pipe.reg_write;
  assign mem_read     = pipe.mem_read;
  assign mem_write    = pipe.mem_write;
  assign illegal      = pipe.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: a vector table streamed through a scoreboard queue,
// then hand-written stall, flush, bubble and asynchronous-reset sequences.
module tb_alu_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] insn;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [5:0]  operation;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [5:0]  shift_amount;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  alu_decode_stage #(.NOP_WORD(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .insn         (insn),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .stall        (stall),
    .flush        (flush),
    .out_valid    (out_valid),
    .operation    (operation),
    .op1          (op1),
    .op2          (op2),
    .shift_amount (shift_amount),
    .dest_reg     (dest_reg),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // chk = 0 skips op2/shift_amount/dest_reg (and op1 when not valid).
  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        valid;
    logic [5:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  sh;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
    logic        chk;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] i_ins(input int opc, input int rs, input int rt,
                                        input int imm);
    return {opc[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic vec_t mk(input int valid, input logic [31:0] i, input logic [31:0] rs,
                              input logic [31:0] rt, input int op, input logic [31:0] o1,
                              input logic [31:0] o2, input int sh, input int dest,
                              input int rw, input int mr, input int mw, input int ill,
                              input int chk);
    vec_t v;
    v.insn = i;          v.rs = rs;           v.rt = rt;
    v.valid = valid[0];  v.op = op[5:0];      v.op1 = o1;
    v.op2 = o2;          v.sh = sh[5:0];      v.dest = dest[4:0];
    v.rw = rw[0];        v.mr = mr[0];        v.mw = mw[0];
    v.ill = ill[0];      v.chk = chk[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare(input vec_t e, input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e.valid));
    check({tag, ".operation"}, 32'(operation), 32'(e.op));
    check({tag, ".reg_write"}, 32'(reg_write), 32'(e.rw));
    check({tag, ".mem_read"},  32'(mem_read),  32'(e.mr));
    check({tag, ".mem_write"}, 32'(mem_write), 32'(e.mw));
    check({tag, ".illegal"},   32'(illegal),   32'(e.ill));
    if (e.valid || e.chk) check({tag, ".op1"}, op1, e.op1);
    if (e.chk) begin
      check({tag, ".op2"},          op2,                e.op2);
      check({tag, ".shift_amount"}, 32'(shift_amount),  32'(e.sh));
      check({tag, ".dest_reg"},     32'(dest_reg),      32'(e.dest));
    end
  endtask

  // Drive one cycle of stimulus, queue what should appear after the edge, then compare.
  task automatic step(input logic v, input logic s, input logic f, input vec_t d,
                      input vec_t e, input string tag);
    vec_t got;
    @(negedge clk);
    in_valid = v;
    stall    = s;
    flush    = f;
    insn     = d.insn;
    rs_data  = d.rs;
    rt_data  = d.rt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(!s));
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
    end else begin
      got = sb.pop_front();
      compare(got, tag);
    end
  endtask

  vec_t zero_v;
  vec_t bubble_v;
  vec_t and_v;

  initial begin
    zero_v   = mk(0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    bubble_v = mk(0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    and_v    = mk(1, r_ins(1, 2, 18, 0, 'h24), 32'h0000_F0F0, 32'h0000_FF00,
                  7, 32'h0000_F0F0, 32'h0000_FF00, 0, 18, 1, 0, 0, 0, 1);

    //                 valid insn                       rs             rt             op  op1            op2            sh dest rw mr mw il chk
    vecs.push_back(mk(1, r_ins(1, 2, 3, 0, 'h20),    32'd5,         32'd7,          0, 32'd5,         32'd7,          0,  3, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, r_ins(0, 2, 4, 5, 'h00),    32'h99,        32'd1,          4, 32'h99,        32'd1,          5,  4, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, r_ins(8, 7, 6, 0, 'h07),    32'h23,        32'h8000_0000, 11, 32'h23,        32'h8000_0000,  3,  6, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, r_ins(1, 2, 17, 9, 'h06),   32'hFFFF_FFE5, 32'h1234,       5, 32'hFFFF_FFE5, 32'h1234,       5, 17, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, r_ins(1, 2, 13, 0, 'h23),   32'd20,        32'd3,          1, 32'd20,        32'd3,          0, 13, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, r_ins(1, 2, 14, 0, 'h27),   32'h0F,        32'hF0,        10, 32'h0F,        32'hF0,         0, 14, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, r_ins(1, 2, 0, 0, 'h26),    32'h11,        32'h22,         9, 32'h11,        32'h22,         0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, r_ins(3, 4, 20, 0, 'h2A),   32'h1,         32'h2,          6, 32'h1,         32'h2,          0, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, r_ins(1, 2, 0, 0, 'h19),    32'd6,         32'd7,          2, 32'd6,         32'd7,          0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, r_ins(1, 2, 21, 0, 'h1A),   32'd9,         32'd3,          3, 32'd9,         32'd3,          0, 21, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, r_ins(0, 5, 22, 31, 'h03),  32'h7,         32'h8000_0001, 11, 32'h7,         32'h8000_0001, 31, 22, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, i_ins('h08, 1, 5, 'hFC18),  32'd10,        32'h55,         0, 32'd10,        32'hFFFF_FC18,  0,  5, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, i_ins('h0D, 2, 9, 'h8001),  32'h3,         32'h66,         8, 32'h3,         32'h0000_8001,  0,  9, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, i_ins('h0F, 0, 10, 'h1234), 32'hABCD,      32'h77,        12, 32'hABCD,      32'h0000_1234,  0, 10, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, i_ins('h2B, 2, 11, 8),      32'h100,       32'hDEAD,       0, 32'h100,       32'd8,          0, 11, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, i_ins('h23, 3, 0, 4),       32'h200,       32'h5,          0, 32'h200,       32'd4,          0,  0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, i_ins('h23, 3, 12, 'hFFFC), 32'h300,       32'h5,          0, 32'h300,       32'hFFFF_FFFC,  0, 12, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, i_ins('h0A, 1, 15, 'h8000), 32'h4,         32'h5,          6, 32'h4,         32'hFFFF_8000,  0, 15, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, i_ins('h0C, 1, 16, 'hFFFF), 32'h4,         32'h5,          7, 32'h4,         32'h0000_FFFF,  0, 16, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, i_ins('h0E, 1, 19, 'hF000), 32'h4,         32'h5,          9, 32'h4,         32'h0000_F000,  0, 19, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, i_ins('h09, 1, 23, 'h7FFF), 32'h4,         32'h5,          0, 32'h4,         32'h0000_7FFF,  0, 23, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, i_ins('h3F, 1, 2, 'h1234),  32'hCAFE,      32'h5,          0, 32'hCAFE,      32'h0,          0,  0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, r_ins(1, 2, 3, 0, 'h01),    32'hBEEF,      32'h5,          0, 32'hBEEF,      32'h0,          0,  0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, i_ins('h0B, 1, 2, 'h0010),  32'h1,         32'h5,          0, 32'h1,         32'h0,          0,  0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0000_0000,              32'h11,        32'h22,         0, 32'h11,        32'h0,          0,  0, 0, 0, 0, 0, 0));

    // Reset state, checked before any clock edge.
    rst_n    = 1'b1;
    in_valid = 1'b0;
    stall    = 1'b1;
    flush    = 1'b0;
    insn     = '0;
    rs_data  = '0;
    rt_data  = '0;
    #2 rst_n = 1'b0;
    #1;
    compare(zero_v, "reset");
    check("reset.in_ready_stalled", 32'(in_ready), 32'd0);
    stall = 1'b0;
    #1;
    check("reset.in_ready_free", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table streamed back to back.
    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b1, 1'b0, 1'b0, vecs[i], vecs[i], $sformatf("vec%0d", i));
    end

    // Load, then hold for three stalled cycles while the input keeps changing.
    step(1'b1, 1'b0, 1'b0, and_v, and_v, "and_load");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, vecs[i + 1], and_v, $sformatf("stall%0d", i));
    end
    step(1'b1, 1'b1, 1'b1, vecs[0], zero_v, "stall_flush");

    // Flush alone drops a valid input; an idle cycle leaves a bubble.
    step(1'b1, 1'b0, 1'b0, vecs[11], vecs[11], "reload");
    step(1'b1, 1'b0, 1'b1, vecs[12], zero_v, "flush_only");
    step(1'b1, 1'b0, 1'b0, vecs[13], vecs[13], "reload2");
    step(1'b0, 1'b0, 1'b0, vecs[14], bubble_v, "idle_bubble");

    // Asynchronous reset in the middle of a stall clears everything at once.
    step(1'b1, 1'b0, 1'b0, vecs[0], vecs[0], "pre_reset");
    @(negedge clk);
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    compare(zero_v, "mid_reset");
    check("mid_reset.in_ready_stalled", 32'(in_ready), 32'd0);
    stall = 1'b0;
    #1;
    check("mid_reset.in_ready_free", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, vecs[2], vecs[2], "post_reset");

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
